// File: rtl/flow_key_pkg.sv
// Shared constants, key layout and state types for the flow key builder.
// Also holds the key packing and saturating-counter helpers.
package flow_key_pkg;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  PROTO_TCP     = 8'd6;
    localparam logic [7:0]  PROTO_UDP     = 8'd17;

    localparam int unsigned KEY_W        = 104;
    localparam int unsigned SRC_IP_LSB   = 72;
    localparam int unsigned DST_IP_LSB   = 40;
    localparam int unsigned SRC_PORT_LSB = 24;
    localparam int unsigned DST_PORT_LSB = 8;
    localparam int unsigned PROTO_LSB    = 0;

    typedef enum logic [1:0] {
        KeyMode5Tuple  = 2'd0,
        KeyMode3Tuple  = 2'd1,
        KeyModeDstOnly = 2'd2,
        KeyModeRsvd    = 2'd3
    } key_mode_e;

    typedef enum logic [1:0] {
        KeyClassL4    = 2'd0,
        KeyClassL3    = 2'd1,
        KeyClassNonIp = 2'd2
    } key_class_e;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWaitEth = 2'd1,
        StWaitIp  = 2'd2,
        StWaitL4  = 2'd3
    } fsm_state_e;

    function automatic logic [KEY_W-1:0] pack_key(
        input logic [31:0] src_ip,
        input logic [31:0] dst_ip,
        input logic [15:0] src_port,
        input logic [15:0] dst_port,
        input logic [7:0]  proto
    );
        logic [KEY_W-1:0] key;
        key                         = '0;
        key[SRC_IP_LSB +: 32]       = src_ip;
        key[DST_IP_LSB +: 32]       = dst_ip;
        key[SRC_PORT_LSB +: 16]     = src_port;
        key[DST_PORT_LSB +: 16]     = dst_port;
        key[PROTO_LSB +: 8]         = proto;
        return key;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic en);
        return (en && (cnt != 16'hFFFF)) ? cnt + 16'd1 : cnt;
    endfunction

endpackage

// File: rtl/flow_key_builder_if.sv
// Parser-side inputs and lookup-side key handshake of the flow key builder.
// slave is the builder's view, master is the parser/consumer view.
interface flow_key_builder_if #(
    parameter int unsigned KEY_WIDTH = 104
);
    logic                 pkt_start;
    logic [1:0]           key_mode;
    logic [15:0]          eth_type;
    logic                 eth_parser_ready;
    logic [31:0]          src_ip;
    logic [31:0]          dst_ip;
    logic [7:0]           protocol;
    logic                 ipv4_parser_ready;
    logic [15:0]          udp_src_port;
    logic [15:0]          udp_dst_port;
    logic [15:0]          tcp_src_port;
    logic [15:0]          tcp_dst_port;
    logic                 udp_tcp_parser_ready;
    logic [KEY_WIDTH-1:0] flow_key;
    logic [1:0]           key_class;
    logic                 key_valid;
    logic                 key_ready;
    logic [15:0]          abort_cnt;
    logic [15:0]          timeout_cnt;
    logic [15:0]          drop_cnt;

    modport master (
        output pkt_start, key_mode, eth_type, eth_parser_ready, src_ip, dst_ip, protocol,
               ipv4_parser_ready, udp_src_port, udp_dst_port, tcp_src_port, tcp_dst_port,
               udp_tcp_parser_ready, key_ready,
        input  flow_key, key_class, key_valid, abort_cnt, timeout_cnt, drop_cnt
    );

    modport slave (
        input  pkt_start, key_mode, eth_type, eth_parser_ready, src_ip, dst_ip, protocol,
               ipv4_parser_ready, udp_src_port, udp_dst_port, tcp_src_port, tcp_dst_port,
               udp_tcp_parser_ready, key_ready,
        output flow_key, key_class, key_valid, abort_cnt, timeout_cnt, drop_cnt
    );

endinterface

// File: rtl/flow_key_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is accepted only when
// a pop happens in the same cycle.
module flow_key_fifo #(
    parameter int unsigned WIDTH = 106,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CntW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    // Storage needs no reset: the head is only observed when not empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/flow_key_builder.sv
// Tracks one packet through Ethernet, IPv4 and L4 parser results, builds a
// configurable flow key and queues it for the match-action lookup.
module flow_key_builder
    import flow_key_pkg::*;
#(
    parameter int unsigned KEY_WIDTH      = 104,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input logic               clk,
    input logic               rst_n,
    flow_key_builder_if.slave bus
);
    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned EntryW = KEY_WIDTH + 2;

    fsm_state_e       state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    key_mode_e        mode_q;
    logic [15:0]      eth_type_q;
    logic [31:0]      src_ip_q, dst_ip_q;
    logic [7:0]       proto_q;
    logic [15:0]      udp_src_q, udp_dst_q, tcp_src_q, tcp_dst_q;
    logic             eth_seen_q, ip_seen_q, l4_seen_q;
    logic [15:0]      abort_cnt_q, timeout_cnt_q, drop_cnt_q;

    logic             push, pop, abort_inc, timeout_inc, drop_inc;
    logic [KEY_W-1:0] push_key;
    key_class_e       push_class;
    logic [EntryW-1:0] head;
    logic             fifo_full, fifo_empty;

    // A new packet clears everything captured for the previous one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= KeyMode5Tuple;
            eth_type_q <= '0;
            src_ip_q   <= '0;
            dst_ip_q   <= '0;
            proto_q    <= '0;
            udp_src_q  <= '0;
            udp_dst_q  <= '0;
            tcp_src_q  <= '0;
            tcp_dst_q  <= '0;
            eth_seen_q <= 1'b0;
            ip_seen_q  <= 1'b0;
            l4_seen_q  <= 1'b0;
        end else if (bus.pkt_start) begin
            eth_seen_q <= 1'b0;
            ip_seen_q  <= 1'b0;
            l4_seen_q  <= 1'b0;
            mode_q     <= (key_mode_e'(bus.key_mode) == KeyModeRsvd) ? KeyMode5Tuple
                                                                      : key_mode_e'(bus.key_mode);
        end else if (state_q != StIdle) begin
            if (bus.eth_parser_ready) begin
                eth_type_q <= bus.eth_type;
                eth_seen_q <= 1'b1;
            end
            if (bus.ipv4_parser_ready) begin
                src_ip_q  <= bus.src_ip;
                dst_ip_q  <= bus.dst_ip;
                proto_q   <= bus.protocol;
                ip_seen_q <= 1'b1;
            end
            if (bus.udp_tcp_parser_ready) begin
                udp_src_q <= bus.udp_src_port;
                udp_dst_q <= bus.udp_dst_port;
                tcp_src_q <= bus.tcp_src_port;
                tcp_dst_q <= bus.tcp_dst_port;
                l4_seen_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = '0;
        push        = 1'b0;
        push_key    = '0;
        push_class  = KeyClassL4;
        abort_inc   = 1'b0;
        timeout_inc = 1'b0;
        if (bus.pkt_start) begin
            state_d   = StWaitEth;
            abort_inc = (state_q != StIdle);
        end else begin
            unique case (state_q)
                StIdle: begin
                end
                StWaitEth: begin
                    if (eth_seen_q) begin
                        if (eth_type_q == ETH_TYPE_IPV4) begin
                            state_d = StWaitIp;
                        end else begin
                            push       = 1'b1;
                            push_key   = KEY_W'(eth_type_q);
                            push_class = KeyClassNonIp;
                            state_d    = StIdle;
                        end
                    end
                end
                StWaitIp: begin
                    if (ip_seen_q) begin
                        if ((mode_q == KeyMode5Tuple) &&
                            ((proto_q == PROTO_TCP) || (proto_q == PROTO_UDP))) begin
                            state_d = StWaitL4;
                        end else begin
                            push       = 1'b1;
                            push_class = KeyClassL3;
                            state_d    = StIdle;
                            if (mode_q == KeyModeDstOnly) begin
                                push_key = pack_key('0, dst_ip_q, '0, '0, '0);
                            end else begin
                                push_key = pack_key(src_ip_q, dst_ip_q, '0, '0, proto_q);
                            end
                        end
                    end
                end
                StWaitL4: begin
                    if (l4_seen_q) begin
                        push       = 1'b1;
                        push_class = KeyClassL4;
                        state_d    = StIdle;
                        if (proto_q == PROTO_TCP) begin
                            push_key = pack_key(src_ip_q, dst_ip_q, tcp_src_q, tcp_dst_q, proto_q);
                        end else begin
                            push_key = pack_key(src_ip_q, dst_ip_q, udp_src_q, udp_dst_q, proto_q);
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
            // Timer only runs while a WAIT state makes no progress.
            if ((state_q != StIdle) && (state_d == state_q)) begin
                if (timer_q == TimerW'(TIMEOUT_CYCLES)) begin
                    timeout_inc = 1'b1;
                    state_d     = StIdle;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            timer_q       <= '0;
            abort_cnt_q   <= '0;
            timeout_cnt_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            abort_cnt_q   <= sat_inc(abort_cnt_q, abort_inc);
            timeout_cnt_q <= sat_inc(timeout_cnt_q, timeout_inc);
            drop_cnt_q    <= sat_inc(drop_cnt_q, drop_inc);
        end
    end

    assign pop      = bus.key_ready && !fifo_empty;
    assign drop_inc = push && fifo_full && !pop;

    flow_key_fifo #(
        .WIDTH (EntryW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({push_class, push_key}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.key_valid   = !fifo_empty;
    assign bus.flow_key    = fifo_empty ? '0 : head[KEY_WIDTH-1:0];
    assign bus.key_class   = fifo_empty ? 2'b00 : head[EntryW-1 -: 2];
    assign bus.abort_cnt   = abort_cnt_q;
    assign bus.timeout_cnt = timeout_cnt_q;
    assign bus.drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_flow_key_builder.sv
// Directed self-checking bench for flow_key_builder with hand-computed keys.
module tb_flow_key_builder;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    flow_key_builder_if #(.KEY_WIDTH(104)) bus ();

    flow_key_builder #(
        .KEY_WIDTH      (104),
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [103:0] obs, input logic [103:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_pkt(input logic [1:0] mode);
        bus.pkt_start = 1'b1;
        bus.key_mode  = mode;
        tick();
        bus.pkt_start = 1'b0;
    endtask

    task automatic send_eth(input logic [15:0] t);
        bus.eth_type         = t;
        bus.eth_parser_ready = 1'b1;
        tick();
        bus.eth_parser_ready = 1'b0;
    endtask

    task automatic send_ip(input logic [31:0] s, input logic [31:0] d, input logic [7:0] p);
        bus.src_ip            = s;
        bus.dst_ip            = d;
        bus.protocol          = p;
        bus.ipv4_parser_ready = 1'b1;
        tick();
        bus.ipv4_parser_ready = 1'b0;
    endtask

    task automatic send_l4(input logic [15:0] us, input logic [15:0] ud,
                           input logic [15:0] ts, input logic [15:0] td);
        bus.udp_src_port         = us;
        bus.udp_dst_port         = ud;
        bus.tcp_src_port         = ts;
        bus.tcp_dst_port         = td;
        bus.udp_tcp_parser_ready = 1'b1;
        tick();
        bus.udp_tcp_parser_ready = 1'b0;
    endtask

    task automatic pop_one();
        bus.key_ready = 1'b1;
        tick();
        bus.key_ready = 1'b0;
    endtask

    task automatic push_nonip(input logic [15:0] t);
        start_pkt(2'd0);
        send_eth(t);
        tick();
    endtask

    initial begin
        rst_n                    = 1'b0;
        bus.pkt_start            = 1'b0;
        bus.key_mode             = 2'd0;
        bus.eth_type             = '0;
        bus.eth_parser_ready     = 1'b0;
        bus.src_ip               = '0;
        bus.dst_ip               = '0;
        bus.protocol             = '0;
        bus.ipv4_parser_ready    = 1'b0;
        bus.udp_src_port         = '0;
        bus.udp_dst_port         = '0;
        bus.tcp_src_port         = '0;
        bus.tcp_dst_port         = '0;
        bus.udp_tcp_parser_ready = 1'b0;
        bus.key_ready            = 1'b0;
        #12;
        chk("rst_valid", bus.key_valid, 0);
        chk("rst_key", bus.flow_key, 0);
        chk("rst_class", bus.key_class, 0);
        chk("rst_abort", bus.abort_cnt, 0);
        chk("rst_timeout", bus.timeout_cnt, 0);
        chk("rst_drop", bus.drop_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Mode 0 TCP 5-tuple, valid two cycles after the L4 ready.
        start_pkt(2'd0);
        send_eth(16'h0800);
        send_ip(32'h0A000001, 32'h0A000002, 8'd6);
        send_l4(16'd7, 16'd7, 16'd1234, 16'd80);
        chk("tcp_valid_n1", bus.key_valid, 0);
        tick();
        chk("tcp_valid_n2", bus.key_valid, 1);
        chk("tcp_key", bus.flow_key, 104'h0A000001_0A000002_04D2_0050_06);
        chk("tcp_class", bus.key_class, 0);
        pop_one();
        chk("tcp_popped", bus.key_valid, 0);

        // Mode 1 UDP: L3 key without waiting for L4.
        bus.udp_src_port = 16'd53;
        bus.udp_dst_port = 16'd53;
        start_pkt(2'd1);
        send_eth(16'h0800);
        send_ip(32'h0A000001, 32'h0A000002, 8'd17);
        chk("m1_valid_n1", bus.key_valid, 0);
        tick();
        chk("m1_key", bus.flow_key, 104'h0A000001_0A000002_0000_0000_11);
        chk("m1_class", bus.key_class, 1);
        pop_one();

        // Mode 2: destination only.
        start_pkt(2'd2);
        send_eth(16'h0800);
        send_ip(32'h0A010203, 32'h0A040506, 8'd6);
        tick();
        chk("m2_key", bus.flow_key, 104'h00000000_0A040506_0000_0000_00);
        chk("m2_class", bus.key_class, 1);
        pop_one();

        // Reserved mode behaves as 5-tuple.
        start_pkt(2'd3);
        send_eth(16'h0800);
        send_ip(32'h0A000001, 32'h0A000002, 8'd17);
        send_l4(16'd53, 16'd53, 16'd9, 16'd9);
        tick();
        chk("m3_key", bus.flow_key, 104'h0A000001_0A000002_0035_0035_11);
        chk("m3_class", bus.key_class, 0);
        pop_one();

        // Non-IPv4.
        start_pkt(2'd0);
        send_eth(16'h86DD);
        chk("v6_valid_n1", bus.key_valid, 0);
        tick();
        chk("v6_key", bus.flow_key, 104'h86DD);
        chk("v6_class", bus.key_class, 2);
        pop_one();

        // All three readies together: pushed three cycles later.
        start_pkt(2'd0);
        bus.eth_type             = 16'h0800;
        bus.src_ip               = 32'hC0A8010A;
        bus.dst_ip               = 32'hC0A80114;
        bus.protocol             = 8'd17;
        bus.udp_src_port         = 16'd5000;
        bus.udp_dst_port         = 16'd6000;
        bus.tcp_src_port         = 16'd1111;
        bus.tcp_dst_port         = 16'd2222;
        bus.eth_parser_ready     = 1'b1;
        bus.ipv4_parser_ready    = 1'b1;
        bus.udp_tcp_parser_ready = 1'b1;
        tick();
        bus.eth_parser_ready     = 1'b0;
        bus.ipv4_parser_ready    = 1'b0;
        bus.udp_tcp_parser_ready = 1'b0;
        tick();
        tick();
        chk("all3_valid_early", bus.key_valid, 0);
        tick();
        chk("all3_valid", bus.key_valid, 1);
        chk("all3_key", bus.flow_key, 104'hC0A8010A_C0A80114_1388_1770_11);
        chk("all3_class", bus.key_class, 0);
        pop_one();

        // Stall in WAIT_L4 until timeout.
        start_pkt(2'd0);
        send_eth(16'h0800);
        send_ip(32'h01020304, 32'h05060708, 8'd6);
        tick();
        repeat (30) tick();
        chk("to_early", bus.timeout_cnt, 0);
        repeat (50) tick();
        chk("to_cnt", bus.timeout_cnt, 1);
        chk("to_nokey", bus.key_valid, 0);

        // Abort in WAIT_IP, then the new packet completes.
        start_pkt(2'd0);
        send_eth(16'h0800);
        tick();
        tick();
        start_pkt(2'd1);
        chk("abort_cnt", bus.abort_cnt, 1);
        send_eth(16'h0800);
        send_ip(32'hC0000201, 32'hC0000202, 8'd17);
        tick();
        chk("abort_key", bus.flow_key, 104'hC0000201_C0000202_0000_0000_11);
        chk("abort_class", bus.key_class, 1);
        chk("abort_to", bus.timeout_cnt, 1);
        pop_one();

        // Six keys into a depth-4 FIFO with no consumer.
        for (int i = 0; i < 6; i++) push_nonip(16'h1000 + 16'(i));
        chk("drop_cnt", bus.drop_cnt, 2);
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", bus.flow_key, 104'h1000 + 104'(i));
            pop_one();
        end
        chk("drain_empty", bus.key_valid, 0);

        // Push into a full FIFO with a simultaneous pop.
        for (int i = 0; i < 4; i++) push_nonip(16'h2000 + 16'(i));
        start_pkt(2'd0);
        send_eth(16'h2004);
        bus.key_ready = 1'b1;
        tick();
        bus.key_ready = 1'b0;
        chk("bypass_nodrop", bus.drop_cnt, 2);
        for (int i = 1; i < 5; i++) begin
            chk("bypass_order", bus.flow_key, 104'h2000 + 104'(i));
            pop_one();
        end
        chk("bypass_empty", bus.key_valid, 0);

        // Asynchronous reset mid-WAIT_IP with two keys queued.
        push_nonip(16'h3000);
        push_nonip(16'h3001);
        start_pkt(2'd0);
        send_eth(16'h0800);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", bus.key_valid, 0);
        chk("arst_key", bus.flow_key, 0);
        chk("arst_drop", bus.drop_cnt, 0);
        chk("arst_abort", bus.abort_cnt, 0);
        chk("arst_timeout", bus.timeout_cnt, 0);
        rst_n = 1'b1;
        tick();
        start_pkt(2'd0);
        send_eth(16'h0800);
        send_ip(32'h0A000001, 32'h0A000002, 8'd6);
        send_l4(16'd7, 16'd7, 16'd1234, 16'd80);
        tick();
        chk("post_rst_key", bus.flow_key, 104'h0A000001_0A000002_04D2_0050_06);
        chk("post_rst_abort", bus.abort_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
